// File: rtl/stream_demux_1to2.sv
// One-input, two-output valid/ready stream demultiplexer with one registered slot per output
// and a wrapping handshake counter per output.
module stream_demux_1to2 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  output logic              y0_valid,
  input  logic              y0_ready,
  output logic [DATA_W-1:0] y0_data,
  output logic              y1_valid,
  input  logic              y1_ready,
  output logic [DATA_W-1:0] y1_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  logic slot0_free;
  logic slot1_free;
  logic accept;
  logic load0;
  logic load1;
  logic fire0;
  logic fire1;

  // Readiness looks only at the addressed slot, so a stalled port never blocks the other one.
  always_comb begin
    slot0_free = !y0_valid || y0_ready;
    slot1_free = !y1_valid || y1_ready;
    in_ready   = in_sel ? slot1_free : slot0_free;
    accept     = in_valid && in_ready;
    load0      = accept && !in_sel;
    load1      = accept && in_sel;
    fire0      = y0_valid && y0_ready;
    fire1      = y1_valid && y1_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0_valid <= 1'b0;
      y0_data  <= '0;
    end else if (load0) begin
      y0_valid <= 1'b1;
      y0_data  <= in_data;
    end else if (fire0) begin
      y0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1_valid <= 1'b0;
      y1_data  <= '0;
    end else if (load1) begin
      y1_valid <= 1'b1;
      y1_data  <= in_data;
    end else if (fire1) begin
      y1_valid <= 1'b0;
    end
  end

  // Clear wins over a coincident downstream handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (cnt_clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (fire0) cnt0 <= cnt0 + 1'b1;
      if (fire1) cnt1 <= cnt1 + 1'b1;
    end
  end

endmodule
